// File: rtl/hold_seq_pkg.sv
// Shared types for the round-robin sample-and-hold sequencer.
package hold_seq_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        HOLD  = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/hold_len_timer.sv
// Hold-length timer: counts cycles spent in HOLD and flags the last one.
module hold_len_timer #(
    parameter int HLEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [HLEN_W-1:0] eff_len,
    output logic [HLEN_W-1:0] timer,
    output logic              expire
);

    localparam logic [HLEN_W-1:0] ONE = 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (clr) begin
            timer <= '0;
        end else if (en) begin
            timer <= timer + ONE;
        end
    end

    assign expire = en && (timer == eff_len - ONE);

endmodule

// File: rtl/hold_seq_ctrl.sv
// Tick-counting hold sequencer stepping a one-hot enable across N_CH channels.
// Optional HOLD_OVERRUN_EN adds a sticky flag for ticks dropped in HOLD/GAP.
module hold_seq_ctrl
    import hold_seq_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int N_CH   = 4,
    parameter int HLEN_W = 8,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef HOLD_OVERRUN_EN
    input  logic              clr_overrun,
    output logic              overrun,
`endif
    input  logic              hold_tick,
    input  logic              release_tick,
    input  logic [CNT_W-1:0]  threshold,
    input  logic              auto_mode,
    input  logic [HLEN_W-1:0] hold_len,
    output logic [N_CH-1:0]   hold_enable,
    output logic [CNT_W-1:0]  hold_count,
    output logic [CH_W-1:0]   ch_ptr,
    output logic              hold_active,
    output logic              hold_done
);

    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [HLEN_W-1:0] LEN_ONE = 1;
    localparam logic [N_CH-1:0]   EN_ONE  = 1;
    localparam logic [CH_W-1:0]   CH_ONE  = 1;
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(N_CH - 1);

    state_t            state;
    logic              auto_q;
    logic [HLEN_W-1:0] len_q;
    logic [HLEN_W-1:0] timer;
    logic              expire;
    logic [CNT_W-1:0]  eff_thr;
    logic [HLEN_W-1:0] eff_len;
    logic              thr_hit;
    logic              rel;

    assign eff_thr = (threshold == '0) ? CNT_ONE : threshold;
    assign eff_len = (hold_len == '0) ? LEN_ONE : hold_len;
    // >= so a threshold lowered mid-count fires on the next tick
    assign thr_hit = hold_count >= (eff_thr - CNT_ONE);
    assign rel     = release_tick || ((auto_q == MODE_AUTO) && expire);

    hold_len_timer #(
        .HLEN_W (HLEN_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == GAP),
        .en      (state == HOLD),
        .eff_len (len_q),
        .timer   (timer),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COUNT;
            hold_enable <= '0;
            hold_count  <= '0;
            ch_ptr      <= '0;
            hold_done   <= 1'b0;
            auto_q      <= MODE_MANUAL;
            len_q       <= LEN_ONE;
        end else begin
            hold_done <= 1'b0;
            unique case (state)
                COUNT: begin
                    if (hold_tick) begin
                        if (thr_hit) begin
                            hold_enable <= EN_ONE << ch_ptr;
                            hold_count  <= '0;
                            auto_q      <= auto_mode;
                            len_q       <= eff_len;
                            state       <= HOLD;
                        end else begin
                            hold_count <= hold_count + CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (rel) begin
                        hold_enable <= '0;
                        hold_done   <= 1'b1;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    ch_ptr <= (ch_ptr == CH_LAST) ? '0 : ch_ptr + CH_ONE;
                    state  <= COUNT;
                end
                default: state <= COUNT;
            endcase
        end
    end

    assign hold_active = |hold_enable;

`ifdef HOLD_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (hold_tick && (state != COUNT)) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule
